// File: rtl/scan_pkg.sv
// Shared widths, FIFO word layout and default log-to-grey mapping constants
// for the scanline packer.
package scan_pkg;

  localparam int LOG_W = 23;
  localparam int PIX_W = 8;

  localparam logic [LOG_W-1:0] DEF_FLOOR = 23'h100000;
  localparam int               DEF_SHIFT = 13;

  typedef struct packed {
    logic             sof;
    logic             last;
    logic [PIX_W-1:0] pix;
  } pix_word_t;

  // Clamp a shifted log value into the grey-level range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic [LOG_W-1:0] v);
    return (v > LOG_W'((1 << PIX_W) - 1)) ? '1 : v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with occupancy count; a write into an empty FIFO becomes
// visible on the head one cycle later.
module pix_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/scanline_packer.sv
// Maps log-compressed samples to grey pixels, peak-decimates along range,
// tags scanline/frame boundaries and buffers pixels for a ready/valid sink.
module scanline_packer
  import scan_pkg::*;
#(
  parameter logic [LOG_W-1:0] FLOOR           = DEF_FLOOR,
  parameter int               SHIFT           = DEF_SHIFT,
  parameter int               DECIM_LOG2      = 2,
  parameter int               LINE_PIX        = 256,
  parameter int               LINES_PER_FRAME = 128,
  parameter int               FIFO_DEPTH      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       comp_int,
  input  logic [16:0]      comp_frac,
  input  logic             comp_valid,
  input  logic             line_start,
  output logic             in_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             m_sof,
  output logic             overflow,
  output logic             short_line
);

  localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PX_W  = (LINE_PIX > 1) ? $clog2(LINE_PIX) : 1;
  localparam int LN_W  = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WRD_W = $bits(pix_word_t);

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'((1 << DECIM_LOG2) - 1);
  localparam logic [PX_W-1:0]  PX_LAST   = PX_W'(LINE_PIX - 1);
  localparam logic [LN_W-1:0]  LN_LAST   = LN_W'(LINES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 4);

  logic [LOG_W-1:0] x_in;
  logic             accept;

  logic             s1_valid;
  logic             s1_start;
  logic [LOG_W-1:0] s1_d;

  logic [PIX_W-1:0] max_q;
  logic [PH_W-1:0]  phase_q;
  logic [PX_W-1:0]  pix_q;
  logic [LN_W-1:0]  line_q;
  logic             wr_valid;
  pix_word_t        wr_word;

  logic [PIX_W-1:0] s2_pix, cur_max, new_max, max_d;
  logic [PH_W-1:0]  cur_phase, phase_d;
  logic [PX_W-1:0]  eff_pix, pix_d;
  logic [LN_W-1:0]  eff_line, line_d;
  logic             group_end, restart_short;
  pix_word_t        s2_word;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_rd, fifo_wr;
  logic [WRD_W-1:0] fifo_head;
  logic [WRD_W-1:0] fifo_in;
  pix_word_t        head_word;

  assign x_in     = {comp_int, comp_frac};
  assign in_ready = (fifo_count <= READY_MAX);
  assign accept   = comp_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_d     <= '0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_start <= accept & line_start;
      s1_d     <= (x_in > FLOOR) ? (x_in - FLOOR) : '0;
      if (comp_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // A line_start sample opens a fresh group and pixel index; a partially
  // filled line is closed early by bumping the line index.
  always_comb begin
    s2_pix        = sat_pix(s1_d >> SHIFT);
    cur_max       = s1_start ? '0 : max_q;
    cur_phase     = s1_start ? '0 : phase_q;
    new_max       = (s2_pix > cur_max) ? s2_pix : cur_max;
    group_end     = s1_valid && (cur_phase == PH_LAST);
    restart_short = s1_valid && s1_start && (pix_q != '0);
    eff_pix       = (s1_valid && s1_start) ? '0 : pix_q;
    eff_line      = line_q;
    if (restart_short) eff_line = (line_q == LN_LAST) ? '0 : line_q + LN_W'(1);

    s2_word.sof  = (eff_line == '0) && (eff_pix == '0);
    s2_word.last = (eff_pix == PX_LAST);
    s2_word.pix  = new_max;

    max_d   = max_q;
    phase_d = phase_q;
    pix_d   = pix_q;
    line_d  = line_q;
    if (s1_valid) begin
      if (group_end) begin
        max_d   = '0;
        phase_d = '0;
        pix_d   = s2_word.last ? '0 : eff_pix + PX_W'(1);
        line_d  = eff_line;
        if (s2_word.last) line_d = (eff_line == LN_LAST) ? '0 : eff_line + LN_W'(1);
      end else begin
        max_d   = new_max;
        phase_d = cur_phase + PH_W'(1);
        pix_d   = eff_pix;
        line_d  = eff_line;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      max_q      <= '0;
      phase_q    <= '0;
      pix_q      <= '0;
      line_q     <= '0;
      short_line <= 1'b0;
      wr_valid   <= 1'b0;
      wr_word    <= '0;
    end else begin
      max_q    <= max_d;
      phase_q  <= phase_d;
      pix_q    <= pix_d;
      line_q   <= line_d;
      wr_valid <= group_end;
      wr_word  <= s2_word;
      if (restart_short) short_line <= 1'b1;
    end
  end

  assign fifo_in   = wr_word;
  assign fifo_wr   = wr_valid & (~fifo_full | fifo_rd);
  assign fifo_rd   = ~fifo_empty & (~m_valid | m_ready);
  assign head_word = pix_word_t'(fifo_head);

  pix_fifo #(
    .WIDTH (WRD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (fifo_in),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output register holds the current pixel stable until the sink takes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_sof   <= 1'b0;
    end else if (fifo_rd) begin
      m_valid <= 1'b1;
      m_data  <= head_word.pix;
      m_last  <= head_word.last;
      m_sof   <= head_word.sof;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scanline_packer.sv
// Directed self-checking bench: one undecimated instance for the grey mapping,
// one 4:1 decimating instance for grouping, framing, back-pressure and reset.
module tb_scanline_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [5:0]  comp_int;
  logic [16:0] comp_frac;
  logic        comp_valid;
  logic        line_start;
  logic        m_ready;

  logic       in_ready_a, m_valid_a, m_last_a, m_sof_a, overflow_a, short_line_a;
  logic [7:0] m_data_a;
  logic       in_ready_b, m_valid_b, m_last_b, m_sof_b, overflow_b, short_line_b;
  logic [7:0] m_data_b;

  scanline_packer #(.DECIM_LOG2(0), .LINE_PIX(4), .LINES_PER_FRAME(2)) dut_a (
    .clk(clk), .reset(reset), .comp_int(comp_int), .comp_frac(comp_frac),
    .comp_valid(comp_valid), .line_start(line_start), .in_ready(in_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a),
    .m_sof(m_sof_a), .overflow(overflow_a), .short_line(short_line_a)
  );

  scanline_packer #(.DECIM_LOG2(2), .LINE_PIX(4), .LINES_PER_FRAME(2)) dut_b (
    .clk(clk), .reset(reset), .comp_int(comp_int), .comp_frac(comp_frac),
    .comp_valid(comp_valid), .line_start(line_start), .in_ready(in_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b),
    .m_sof(m_sof_b), .overflow(overflow_b), .short_line(short_line_b)
  );

  typedef struct {
    int iv;
    int fv;
    int exp_pix;
    bit exp_sof;
    bit exp_last;
  } map_vec_t;

  typedef struct {
    int s0;
    int s1;
    int s2;
    int s3;
    int exp_pix;
    bit exp_sof;
    bit exp_last;
  } grp_vec_t;

  int         total = 0;
  int         bad = 0;
  logic [9:0] cap_a[$];
  logic [9:0] cap_b[$];

  // Record every completed handshake; inputs only change just after posedge.
  always @(negedge clk) begin
    if (m_valid_a && m_ready) cap_a.push_back({m_sof_a, m_last_a, m_data_a});
    if (m_valid_b && m_ready) cap_b.push_back({m_sof_b, m_last_b, m_data_b});
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int iv, input int fv, input bit ls);
    comp_int   = 6'(iv);
    comp_frac  = 17'(fv);
    line_start = ls;
    comp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    comp_valid = 1'b0;
    line_start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    comp_valid = 1'b0;
    line_start = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [9:0] cap_b_at(input int i);
    return (i < cap_b.size()) ? cap_b[i] : 10'h3FF;
  endfunction

  task automatic checkWord(input string name, input logic [9:0] w,
                           input int pix, input bit sof, input bit last);
    checkOutput({name, "_pix"}, int'(w[7:0]), pix);
    checkOutput({name, "_sof"}, int'(w[9]), int'(sof));
    checkOutput({name, "_last"}, int'(w[8]), int'(last));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    map_vec_t   map_tab[4];
    grp_vec_t   grp_tab[4];
    logic [9:0] w;
    int         acc_n;
    int         first_low;
    int         exp_sl[7];
    bit         exp_sl_sof[7];
    bit         exp_sl_last[7];

    map_tab[0] = '{9,  0,       16,  1'b1, 1'b0};
    map_tab[1] = '{7,  0,       0,   1'b0, 1'b0};
    map_tab[2] = '{40, 0,       255, 1'b0, 1'b0};
    map_tab[3] = '{8,  'h10000, 8,   1'b0, 1'b1};

    grp_tab[0] = '{9,  12, 10, 8, 64,  1'b1, 1'b0};
    grp_tab[1] = '{8,  8,  8,  8, 0,   1'b0, 1'b0};
    grp_tab[2] = '{7,  20, 9,  8, 192, 1'b0, 1'b0};
    grp_tab[3] = '{15, 30, 0,  0, 255, 1'b0, 1'b1};

    exp_sl      = '{16, 16, 32, 48, 48, 48, 64};
    exp_sl_sof  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_sl_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset      = 1'b0;
    comp_int   = '0;
    comp_frac  = '0;
    comp_valid = 1'b0;
    line_start = 1'b0;
    m_ready    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Grey mapping and pipeline latency, no decimation.
    checkOutput("rst_in_ready", int'(in_ready_a), 1);
    checkOutput("rst_m_valid", int'(m_valid_a), 0);
    cap_a.delete();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(map_tab[i].iv, map_tab[i].fv, 1'b0);
      if (i == 2) checkOutput("map_latency_k2", int'(m_valid_a), 0);
      if (i == 3) begin
        checkOutput("map_latency_k3", int'(m_valid_a), 1);
        checkOutput("map_first_data", int'(m_data_a), 16);
      end
    end
    idle(8);
    checkOutput("map_count", cap_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      w = (i < cap_a.size()) ? cap_a[i] : 10'h3FF;
      checkWord($sformatf("map%0d", i), w, map_tab[i].exp_pix,
                map_tab[i].exp_sof, map_tab[i].exp_last);
    end
    checkOutput("map_overflow", int'(overflow_a), 0);
    checkOutput("map_short_line", int'(short_line_a), 0);

    // Peak decimation over groups of four.
    do_reset();
    cap_b.delete();
    for (int g = 0; g < 4; g++) begin
      applyStimulus(grp_tab[g].s0, 0, 1'b0);
      applyStimulus(grp_tab[g].s1, 0, 1'b0);
      applyStimulus(grp_tab[g].s2, 0, 1'b0);
      applyStimulus(grp_tab[g].s3, 0, 1'b0);
    end
    idle(8);
    checkOutput("dec_count", cap_b.size(), 4);
    for (int g = 0; g < 4; g++)
      checkWord($sformatf("dec%0d", g), cap_b_at(g), grp_tab[g].exp_pix,
                grp_tab[g].exp_sof, grp_tab[g].exp_last);

    // Framing: 40 samples give 10 pixels over 4-pixel lines, 2-line frames.
    do_reset();
    cap_b.delete();
    for (int n = 0; n < 40; n++) applyStimulus(9 + ((n / 4) % 3), 0, 1'b0);
    idle(10);
    checkOutput("frm_count", cap_b.size(), 10);
    for (int i = 0; i < 10; i++)
      checkWord($sformatf("frm%0d", i), cap_b_at(i), 16 * (1 + (i % 3)),
                (i % 8) == 0, (i % 4) == 3);

    // Back-pressure: stalled sink with continuous input.
    do_reset();
    cap_b.delete();
    m_ready   = 1'b0;
    acc_n     = 0;
    first_low = -1;
    for (int c = 0; c < 80; c++) begin
      comp_int   = 6'(9 + ((acc_n / 4) % 15));
      comp_frac  = '0;
      line_start = 1'b0;
      comp_valid = 1'b1;
      @(negedge clk);
      if (in_ready_b) acc_n++;
      else if (first_low < 0) begin
        first_low = c;
        checkOutput("bp_no_overflow_yet", int'(overflow_b), 0);
      end
      @(posedge clk);
      #1;
    end
    checkOutput("bp_accepted", acc_n, 58);
    checkOutput("bp_in_ready_low", int'(in_ready_b), 0);
    checkOutput("bp_overflow", int'(overflow_b), 1);
    checkOutput("bp_hold_valid", int'(m_valid_b), 1);
    checkOutput("bp_hold_data", int'(m_data_b), 16);
    comp_valid = 1'b0;
    m_ready    = 1'b1;
    idle(30);
    checkOutput("bp_drain_count", cap_b.size(), 14);
    for (int g = 0; g < 14; g++)
      checkOutput($sformatf("bp_drain%0d", g), int'(cap_b_at(g) & 10'h0FF), 16 * (g + 1));
    checkOutput("bp_in_ready_back", int'(in_ready_b), 1);

    // Early line_start: two pixels plus a partial group, then a new line.
    do_reset();
    cap_b.delete();
    m_ready = 1'b1;
    for (int n = 0; n < 8; n++) applyStimulus(9, 0, n == 0);
    checkOutput("sl_clear_before", int'(short_line_b), 0);
    applyStimulus(40, 0, 1'b0);
    applyStimulus(40, 0, 1'b0);
    for (int n = 0; n < 4; n++) applyStimulus(10, 0, n == 0);
    for (int n = 0; n < 12; n++) applyStimulus(11, 0, 1'b0);
    for (int n = 0; n < 4; n++) applyStimulus(12, 0, 1'b0);
    idle(10);
    checkOutput("sl_set", int'(short_line_b), 1);
    checkOutput("sl_count", cap_b.size(), 7);
    for (int i = 0; i < 7; i++)
      checkWord($sformatf("sl%0d", i), cap_b_at(i), exp_sl[i], exp_sl_sof[i], exp_sl_last[i]);

    // One-cycle reset with a full FIFO and sticky flags set.
    m_ready = 1'b0;
    for (int c = 0; c < 80; c++) applyStimulus(13, 0, 1'b0);
    checkOutput("rr_pre_valid", int'(m_valid_b), 1);
    checkOutput("rr_pre_overflow", int'(overflow_b), 1);
    do_reset();
    checkOutput("rr_m_valid", int'(m_valid_b), 0);
    checkOutput("rr_m_data", int'(m_data_b), 0);
    checkOutput("rr_m_sof", int'(m_sof_b), 0);
    checkOutput("rr_m_last", int'(m_last_b), 0);
    checkOutput("rr_overflow", int'(overflow_b), 0);
    checkOutput("rr_short_line", int'(short_line_b), 0);
    checkOutput("rr_in_ready", int'(in_ready_b), 1);
    cap_b.delete();
    m_ready = 1'b1;
    for (int n = 0; n < 4; n++) applyStimulus(14, 0, 1'b0);
    idle(10);
    checkOutput("rr_count", cap_b.size(), 1);
    checkWord("rr_first", cap_b_at(0), 96, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
